// File: rtl/cp0_vec.sv
// Coprocessor 0 for the single-cycle MIPS core: Status/Cause/EPC, a Count/Compare
// timer, NUM_HW sampled interrupt lines and optional vectored interrupt entry.
module cp0_vec #(
  parameter int          NUM_HW      = 6,
  parameter bit          TIMER_EN    = 1'b1,
  parameter logic [31:0] VEC_BASE    = 32'h8000_0180,
  parameter logic [31:0] VEC_SPACING = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [31:0]       pcp4,
  input  logic              alu_trap,
  input  logic              eret,
  input  logic [NUM_HW-1:0] interrupt,
  output logic              exl,
  output logic              ie,
  output logic              exc_take,
  output logic [31:0]       exc_vec,
  output logic              timer_irq
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT      = 5'd0;
  localparam logic [4:0] EXC_TRAP     = 5'd13;

  function automatic logic [7:0] ip_mask_f(input int n, input bit ten);
    logic [7:0] m;
    m = 8'b0000_0011;
    for (int k = 0; k < 6; k++) begin
      m[k+2] = (k < n);
    end
    m[7] = m[7] | ten;
    return m;
  endfunction

  function automatic logic [2:0] top_idx_f(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = v[k] ? 3'(k) : idx;
    end
    return idx;
  endfunction

  // IP/IM bits that exist for this configuration; all others read as 0
  localparam logic [7:0] IP_MASK = ip_mask_f(NUM_HW, TIMER_EN);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [31:0] epc_r;
  logic [31:0] exc_vec_r;
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        iv_r;
  logic [1:0]  sw_ip_r;
  logic [5:0]  hw_ip_r;
  logic [4:0]  exc_code_r;
  logic        timer_pend_r;
  logic        exc_take_r;

  logic [5:0]  irq_pad_s;
  logic [7:0]  ip_s;
  logic [7:0]  masked_s;
  logic        pend_s;
  logic        entry_s;
  logic        capture_epc_s;
  logic [31:0] vec_s;
  logic [31:0] count_next_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;

  // Zero-extend the configured interrupt lines onto the six IP slots
  always_comb begin
    irq_pad_s = 6'd0;
    for (int k = 0; k < NUM_HW; k++) begin
      irq_pad_s[k] = interrupt[k];
    end
  end

  // Write decode, pending-interrupt evaluation and exception-entry selection
  always_comb begin
    wr_count_s    = we && (addr == ADDR_COUNT);
    wr_compare_s  = we && (addr == ADDR_COMPARE);
    wr_status_s   = we && (addr == ADDR_STATUS);
    wr_cause_s    = we && (addr == ADDR_CAUSE);
    wr_epc_s      = we && (addr == ADDR_EPC);
    count_next_s  = wr_count_s ? wd : (count_r + 32'd1);
    ip_s          = {hw_ip_r[5] | (TIMER_EN & timer_pend_r), hw_ip_r[4:0], sw_ip_r} & IP_MASK;
    masked_s      = ip_s & im_r;
    pend_s        = (|masked_s) & ie_r & ~exl_r;
    entry_s       = alu_trap | pend_s;
    // A trap taken while already in exception level keeps the original EPC
    capture_epc_s = (pend_s & ~alu_trap) | (alu_trap & ~exl_r);
    if (!alu_trap && iv_r) begin
      vec_s = VEC_BASE + VEC_SPACING * ({29'd0, top_idx_f(masked_s)} + 32'd1);
    end else begin
      vec_s = VEC_BASE;
    end
  end

  // MFC0 read mux
  always_comb begin
    case (addr)
      ADDR_COUNT:   rd = count_r;
      ADDR_COMPARE: rd = compare_r;
      ADDR_STATUS:  rd = {16'd0, im_r, 6'd0, exl_r, ie_r};
      ADDR_CAUSE:   rd = {8'd0, iv_r, 7'd0, ip_s, 1'b0, exc_code_r, 2'd0};
      ADDR_EPC:     rd = epc_r;
      default:      rd = 32'd0;
    endcase
  end

  // Architectural state, timer and exception-entry handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r      <= 32'd0;
      compare_r    <= 32'hFFFF_FFFF;
      epc_r        <= 32'd0;
      exc_vec_r    <= VEC_BASE;
      im_r         <= 8'd0;
      exl_r        <= 1'b0;
      ie_r         <= 1'b0;
      iv_r         <= 1'b0;
      sw_ip_r      <= 2'd0;
      hw_ip_r      <= 6'd0;
      exc_code_r   <= 5'd0;
      timer_pend_r <= 1'b0;
      exc_take_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      hw_ip_r <= irq_pad_s;
      if (wr_compare_s) begin
        compare_r    <= wd;
        timer_pend_r <= 1'b0;
      end else if (count_next_s == compare_r) begin
        timer_pend_r <= 1'b1;
      end
      if (wr_status_s) begin
        im_r <= wd[15:8] & IP_MASK;
        ie_r <= wd[0];
      end
      if (entry_s) begin
        exl_r <= 1'b1;
      end else if (eret) begin
        exl_r <= 1'b0;
      end else if (wr_status_s) begin
        exl_r <= wd[1];
      end
      if (wr_cause_s) begin
        iv_r    <= wd[23];
        sw_ip_r <= wd[9:8];
      end
      if (entry_s) begin
        exc_code_r <= alu_trap ? EXC_TRAP : EXC_INT;
        exc_vec_r  <= vec_s;
      end
      if (capture_epc_s) begin
        epc_r <= pcp4;
      end else if (wr_epc_s && !entry_s) begin
        epc_r <= wd;
      end
      exc_take_r <= entry_s;
    end
  end

  assign exl       = exl_r;
  assign ie        = ie_r;
  assign exc_take  = exc_take_r;
  assign exc_vec   = exc_vec_r;
  assign timer_irq = timer_pend_r;

endmodule

// File: doc/cp0_vec.md
Name: cp0_vec

Overview:
Parametrised coprocessor-0 for the single-cycle MIPS core, successor to the fixed 6-line CP0. It provides Status, Cause and EPC, plus a Count/Compare timer, a configurable number of hardware interrupt lines and an optional vectored-interrupt mode. It also provides explicit exception-entry and ERET handshakes with the datapath. It sits beside the register file and is accessed through MFC0/MTC0, the ALU trap line, the ERET decode and the external interrupt pins.

Parameters:
NUM_HW, 6, number of hardware interrupt lines (1..6); they map to IP[2+NUM_HW-1:2], and unused IP/IM bits read 0.
TIMER_EN, 1, when 1 the timer pending flag is ORed into IP[7].
VEC_BASE, 32'h8000_0180, exception/interrupt vector base.
VEC_SPACING, 32'h20, byte spacing between interrupt vectors in vectored mode.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  MTC0 write enable
addr  in  5  CP0 register number
wd  in  32  MTC0 write data
rd  out  32  MFC0 read data, combinational from addr
pcp4  in  32  PC+4 of the current instruction, captured into EPC
alu_trap  in  1  ALU overflow/trap request, level, sampled at clk
eret  in  1  ERET executing this cycle
interrupt  in  NUM_HW  hardware interrupt lines, level-sensitive
exl  out  1  Status.EXL
ie  out  1  Status.IE
exc_take  out  1  one-cycle pulse: PC must load exc_vec next
exc_vec  out  32  target vector, valid while exc_take=1
timer_irq  out  1  timer pending flag

Behaviour:
- Register map:
  - 9 Count: RW, increments every clk.
  - 11 Compare: RW.
  - 12 Status: IM[15:8] RW, EXL[1] RW, IE[0] RW.
  - 13 Cause: IV[23] RW, IP[15:10] RO, IP[9:8] RW (software interrupts), ExcCode[6:2] RO.
  - 14 EPC: RW.
  - All other bits and addresses read 0 and ignore writes.
- Reset (async): Status=0, Cause=0, EPC=0, Count=0, Compare=32'hFFFF_FFFF, timer_pend=0, exc_take=0, exc_vec=VEC_BASE.
- IP sampling: IP[2+k] <= interrupt[k] each clk (1-cycle latency); the bit clears when the line drops. IP[7] additionally ORs timer_pend when TIMER_EN=1.
- Timer:
  - Count_next = Count+1, wrapping at 2^32.
  - A write to 9 overrides the increment that cycle.
  - timer_pend sets at the clk where Count_next == Compare.
  - timer_pend clears on any write to 11; if a write and a match occur in the same cycle, the clear wins.
- Pending interrupt: pend = |(IP & IM) & IE & ~EXL, evaluated on the registered IP.
- Exception entry, at a clk edge, in priority order alu_trap > pend:
  - Trap: ExcCode=13; exc_vec=VEC_BASE. If EXL=0, then EPC<=pcp4 and EXL<=1. If EXL=1, EPC is unchanged.
  - Interrupt: ExcCode=0; EPC<=pcp4; EXL<=1. exc_vec is VEC_BASE when IV=0. When IV=1, exc_vec is VEC_BASE + VEC_SPACING*(1+i), where i is the highest set index of IP&IM (7..0).
  - exc_take=1 for exactly the cycle following the edge, then returns to 0. A new entry cannot occur while EXL=1 except by trap.
- ERET: EXL<=0 at the clk edge. If ERET coincides with an entry, the entry wins and EXL stays 1.
- MTC0 and entry in the same cycle: entry fields (EXL, EPC, ExcCode) win; other written fields still update.
- The IP[9:8] software bits are sticky until software writes them to 0.
- rd reflects register state after the last edge. There is no write-through bypass.
- Reset asserted mid-entry: exc_take drops immediately and all state returns to its reset values.

Test Plan:
- Reset, then read addr 9/11/12/13/14 -> 0x0 / 0xFFFF_FFFF / 0x0 / 0x0 / 0x0. Count reads 0x5 after 5 clks.
- Status=0x0000_FF01, pcp4=0x1234_ABCD, interrupt=6'b100001 -> after 1 clk Cause=0x0000_8400. Next clk: exc_take=1, exc_vec=0x8000_0180, EPC=0x1234_ABCD, exl=1. exc_take is 0 the following cycle.
- Cause.IV=1, IM=0xFF, interrupt=6'b000100 -> exc_vec=0x8000_0180+0x20*5=0x8000_0220. Assert eret -> exl=0 next clk; the line is still high, so entry recurs.
- alu_trap=1 with EXL=1 and EPC=0x100 -> ExcCode=13 (Cause[6:2]), EPC stays 0x100, exc_take pulses, exc_vec=VEC_BASE.
- Write Compare=0x10, Count=0x0C, Status=0x8001 -> timer_irq rises when Count reaches 0x10, and Cause IP7=1 with exception taken. A write of Compare clears timer_irq.
- alu_trap and a pending interrupt in the same cycle -> ExcCode=13. Assert rst during the exc_take cycle -> exc_take=0 and Status=0 immediately.
